// File: rtl/dtcm_if.sv
// dtcm_if: LSU-to-DTCM command/response bus with LSU (master) and DTCM (slave) views
interface dtcm_if #(
    parameter int XLEN    = 32,
    parameter int DTCM_AW = 12
);
    logic                 dtcm_cmd_valid;
    logic                 dtcm_cmd_ready;
    logic                 dtcm_cmd_read;
    logic [DTCM_AW-1:0]   dtcm_cmd_addr;
    logic [XLEN-1:0]      dtcm_cmd_wdata;
    logic [XLEN/8-1:0]    dtcm_cmd_wmask;
    logic                 dtcm_rsp_valid;
    logic                 dtcm_rsp_ready;
    logic [XLEN-1:0]      dtcm_rsp_rdata;
    modport master (
        output dtcm_cmd_valid, dtcm_cmd_read, dtcm_cmd_addr, dtcm_cmd_wdata, dtcm_cmd_wmask, dtcm_rsp_ready,
        input  dtcm_cmd_ready, dtcm_rsp_valid, dtcm_rsp_rdata
    );
    modport slave (
        input  dtcm_cmd_valid, dtcm_cmd_read, dtcm_cmd_addr, dtcm_cmd_wdata, dtcm_cmd_wmask, dtcm_rsp_ready,
        output dtcm_cmd_ready, dtcm_rsp_valid, dtcm_rsp_rdata
    );
endinterface

// File: rtl/dtcm_ctrl.sv
// dtcm_ctrl: DTCM word SRAM with byte-masked writes, bypassable response stage and ordered response buffer
module dtcm_ctrl #(
    parameter int XLEN      = 32,
    parameter int DTCM_AW   = 12,
    parameter int RSP_DEPTH = 2
) (
    input logic   clk,
    input logic   rst_n,
    dtcm_if.slave bus
);
    localparam int NB    = XLEN / 8;
    localparam int WORDS = 1 << (DTCM_AW - 2);
    localparam int BD    = RSP_DEPTH - 1;
    localparam int PW    = BD > 1 ? $clog2(BD) : 1;
    localparam int CW    = $clog2(RSP_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);
    localparam logic [CW-1:0] BD_C    = CW'(BD);
    localparam logic [PW-1:0] LAST_C  = PW'(BD - 1);

    logic [XLEN-1:0]    mem [WORDS];
    logic [XLEN-1:0]    rsp_buf [BD];
    logic [PW-1:0]      head, tail;
    logic [CW-1:0]      count;
    logic               s1_valid;
    logic [XLEN-1:0]    s1_data;
    logic [DTCM_AW-3:0] idx;
    logic               accept, nonempty, pop, bypass, push, unused_lo;

    always_comb begin
        idx       = bus.dtcm_cmd_addr[DTCM_AW-1:2];
        unused_lo = ^bus.dtcm_cmd_addr[1:0];
        nonempty  = count != '0;
        bus.dtcm_cmd_ready = (count + CW'(s1_valid)) < DEPTH_C;
        accept    = bus.dtcm_cmd_valid & bus.dtcm_cmd_ready;
        pop       = nonempty & bus.dtcm_rsp_ready;
        bypass    = s1_valid & !nonempty & bus.dtcm_rsp_ready;
        push      = s1_valid & !bypass & ((count != BD_C) | pop);
        bus.dtcm_rsp_valid = nonempty | s1_valid;
        bus.dtcm_rsp_rdata = nonempty ? rsp_buf[head] : s1_data;
    end

    always_ff @(posedge clk) begin
        if (accept & !bus.dtcm_cmd_read)
            for (int i = 0; i < NB; i++)
                if (bus.dtcm_cmd_wmask[i]) mem[idx][8*i +: 8] <= bus.dtcm_cmd_wdata[8*i +: 8];
        if (push) rsp_buf[tail] <= s1_data;
    end

    // S1 only stalls in place when the buffer is full; acceptance is impossible then
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_data  <= bus.dtcm_cmd_read ? mem[idx] : '0;
            end else if (bypass | push) begin
                s1_valid <= 1'b0;
            end
            if (push) tail <= tail == LAST_C ? '0 : tail + 1'b1;
            if (pop)  head <= head == LAST_C ? '0 : head + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_dtcm_ctrl.sv
// tb_dtcm_ctrl: directed checks of dtcm_ctrl latency, masking, ordering, back-pressure and reset
module tb_dtcm_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    dtcm_if #(.XLEN(32), .DTCM_AW(12)) bus ();

    dtcm_ctrl #(.XLEN(32), .DTCM_AW(12), .RSP_DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic v, input logic rd, input logic [11:0] a, input logic [31:0] d, input logic [3:0] m);
        bus.dtcm_cmd_valid = v;
        bus.dtcm_cmd_read  = rd;
        bus.dtcm_cmd_addr  = a;
        bus.dtcm_cmd_wdata = d;
        bus.dtcm_cmd_wmask = m;
    endtask

    initial begin
        cmd(0, 0, 0, 0, 0);
        bus.dtcm_rsp_ready = 1'b1;
        tick();
        tick();
        chk("rst_valid", 32'(bus.dtcm_rsp_valid), 0);
        chk("rst_rdata", bus.dtcm_rsp_rdata, 0);
        chk("rst_ready", 32'(bus.dtcm_cmd_ready), 1);
        rst_n = 1'b1;
        tick();

        cmd(1, 0, 12'h010, 32'hDEADBEEF, 4'hF);
        chk("t1_ready0", 32'(bus.dtcm_cmd_ready), 1);
        tick();
        cmd(1, 1, 12'h010, 0, 0);
        chk("t1_wvalid", 32'(bus.dtcm_rsp_valid), 1);
        chk("t1_wrdata", bus.dtcm_rsp_rdata, 0);
        chk("t1_ready1", 32'(bus.dtcm_cmd_ready), 1);
        tick();
        cmd(0, 0, 0, 0, 0);
        chk("t1_rvalid", 32'(bus.dtcm_rsp_valid), 1);
        chk("t1_rdata", bus.dtcm_rsp_rdata, 32'hDEADBEEF);
        chk("t1_ready2", 32'(bus.dtcm_cmd_ready), 1);
        tick();
        chk("t1_idle", 32'(bus.dtcm_rsp_valid), 0);

        cmd(1, 0, 12'h020, 32'h11223344, 4'hF);
        tick();
        cmd(1, 0, 12'h020, 32'hAABBCCDD, 4'b0101);
        tick();
        cmd(1, 1, 12'h020, 0, 0);
        tick();
        cmd(0, 0, 0, 0, 0);
        chk("t2_mask", bus.dtcm_rsp_rdata, 32'h11BB33DD);
        tick();

        for (int i = 0; i < 4; i++) begin
            cmd(1, 0, 12'(4 * i), 32'(i + 1), 4'hF);
            tick();
        end
        cmd(1, 0, 12'h3FC, 32'h5A5A5A5A, 4'hF);
        tick();
        cmd(0, 0, 0, 0, 0);
        tick();

        for (int i = 0; i < 4; i++) begin
            cmd(1, 1, 12'(4 * i), 0, 0);
            chk("t3_ready", 32'(bus.dtcm_cmd_ready), 1);
            tick();
            chk("t3_valid", 32'(bus.dtcm_rsp_valid), 1);
            chk("t3_rdata", bus.dtcm_rsp_rdata, 32'(i + 1));
        end
        cmd(0, 0, 0, 0, 0);
        tick();
        chk("t3_idle", 32'(bus.dtcm_rsp_valid), 0);

        bus.dtcm_rsp_ready = 1'b0;
        cmd(1, 1, 12'h000, 0, 0);
        chk("t4_ready0", 32'(bus.dtcm_cmd_ready), 1);
        tick();
        chk("t4_ready1", 32'(bus.dtcm_cmd_ready), 1);
        cmd(1, 1, 12'h004, 0, 0);
        tick();
        chk("t4_full", 32'(bus.dtcm_cmd_ready), 0);
        chk("t4_hold0", bus.dtcm_rsp_rdata, 1);
        cmd(1, 1, 12'h008, 0, 0);
        tick();
        chk("t4_full2", 32'(bus.dtcm_cmd_ready), 0);
        chk("t4_hold1", bus.dtcm_rsp_rdata, 1);
        bus.dtcm_rsp_ready = 1'b1;
        tick();
        chk("t4_reopen", 32'(bus.dtcm_cmd_ready), 1);
        chk("t4_rsp2", bus.dtcm_rsp_rdata, 2);
        tick();
        cmd(0, 0, 0, 0, 0);
        chk("t4_v3", 32'(bus.dtcm_rsp_valid), 1);
        chk("t4_rsp3", bus.dtcm_rsp_rdata, 3);
        tick();
        chk("t4_idle", 32'(bus.dtcm_rsp_valid), 0);

        bus.dtcm_rsp_ready = 1'b0;
        cmd(1, 1, 12'h000, 0, 0);
        tick();
        cmd(0, 0, 0, 0, 0);
        tick();
        chk("t5_stall", 32'(bus.dtcm_rsp_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_v", 32'(bus.dtcm_rsp_valid), 0);
        chk("t5_async_r", 32'(bus.dtcm_cmd_ready), 1);
        tick();
        rst_n = 1'b1;
        bus.dtcm_rsp_ready = 1'b1;
        tick();
        chk("t5_stale0", 32'(bus.dtcm_rsp_valid), 0);
        tick();
        chk("t5_stale1", 32'(bus.dtcm_rsp_valid), 0);

        cmd(1, 0, 12'h3FC, 32'hFFFFFFFF, 4'h0);
        tick();
        cmd(1, 1, 12'h3FC, 0, 0);
        chk("t6_wvalid", 32'(bus.dtcm_rsp_valid), 1);
        chk("t6_wrdata", bus.dtcm_rsp_rdata, 0);
        tick();
        cmd(1, 1, 12'h3FE, 0, 0);
        chk("t6_nomask", bus.dtcm_rsp_rdata, 32'h5A5A5A5A);
        tick();
        cmd(0, 0, 0, 0, 0);
        chk("t6_lowbits", bus.dtcm_rsp_rdata, 32'h5A5A5A5A);
        tick();
        chk("t6_idle", 32'(bus.dtcm_rsp_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
